// File: rtl/fetch_sequencer.sv
// Fetch/decode/execute control FSM driving PC strobes, instruction reads and the IR.
// Optional single-step mode (PAUSE state, i_step input) enabled by defining SEQ_STEP_EN.
module fetch_sequencer #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_halt_req,
  input  logic [WIDTH-1:0] i_pc_value,
  input  logic             i_mem_ready,
  input  logic [WIDTH-1:0] i_mem_data,
  input  logic             i_exec_done,
  input  logic             i_jump,
  input  logic [WIDTH-1:0] i_jump_addr,
`ifdef SEQ_STEP_EN
  input  logic             i_step,
`endif
  output logic             o_pc_reset,
  output logic             o_pc_load,
  output logic             o_pc_inc,
  output logic [WIDTH-1:0] o_pc_d_in,
  output logic             o_mem_rd,
  output logic [WIDTH-1:0] o_mem_addr,
  output logic [WIDTH-1:0] o_ir_out,
  output logic             o_ir_valid,
  output logic             o_busy,
  output logic             o_fault
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StUpdate,
    StHalt,
    StFault
`ifdef SEQ_STEP_EN
    ,
    StPause
`endif
  } state_e;

  // Fault fires at the end of the TIMEOUT-th FETCH cycle without mem_ready.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_e           r_state;
  logic [7:0]       r_cnt;
  logic             r_pc_reset;
  logic             r_pc_load;
  logic             r_pc_inc;
  logic [WIDTH-1:0] r_pc_d_in;
  logic             r_mem_rd;
  logic [WIDTH-1:0] r_ir;
  logic             r_ir_valid;
  logic             r_busy;
  logic             r_fault;

  // pc_reset resets high, so it stays high through the first clock after release.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_pc_reset <= 1'b1;
      r_pc_load  <= 1'b0;
      r_pc_inc   <= 1'b0;
      r_pc_d_in  <= '0;
      r_mem_rd   <= 1'b0;
      r_ir       <= '0;
      r_ir_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_pc_reset <= 1'b0;
      r_pc_load  <= 1'b0;
      r_pc_inc   <= 1'b0;
      case (r_state)
        StIdle, StHalt: begin
          if (i_start) begin
            r_state  <= StFetch;
            r_mem_rd <= 1'b1;
            r_busy   <= 1'b1;
            r_cnt    <= '0;
          end
        end
        StFetch: begin
          if (i_mem_ready) begin
            r_ir     <= i_mem_data;
            r_cnt    <= '0;
            r_mem_rd <= 1'b0;
            r_state  <= StDecode;
          end else if (r_cnt == TimeoutLast) begin
            r_state  <= StFault;
            r_fault  <= 1'b1;
            r_mem_rd <= 1'b0;
            r_busy   <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        StDecode: begin
          r_state    <= StExec;
          r_ir_valid <= 1'b1;
        end
        StExec: begin
          if (i_exec_done) begin
            r_state    <= StUpdate;
            r_ir_valid <= 1'b0;
            r_pc_load  <= i_jump;
            r_pc_inc   <= ~i_jump;
            r_pc_d_in  <= i_jump_addr;
          end
        end
        StUpdate: begin
          if (i_halt_req) begin
            r_state <= StHalt;
            r_busy  <= 1'b0;
          end else begin
`ifdef SEQ_STEP_EN
            r_state  <= StPause;
            r_busy   <= 1'b0;
`else
            r_state  <= StFetch;
            r_mem_rd <= 1'b1;
            r_cnt    <= '0;
`endif
          end
        end
`ifdef SEQ_STEP_EN
        StPause: begin
          if (i_halt_req) begin
            r_state <= StHalt;
          end else if (i_step) begin
            r_state  <= StFetch;
            r_mem_rd <= 1'b1;
            r_busy   <= 1'b1;
            r_cnt    <= '0;
          end
        end
`endif
        StFault: begin
          r_mem_rd <= 1'b0;
          r_busy   <= 1'b0;
        end
        default: begin
          r_state    <= StIdle;
          r_mem_rd   <= 1'b0;
          r_busy     <= 1'b0;
          r_ir_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_pc_reset = r_pc_reset;
  assign o_pc_load  = r_pc_load;
  assign o_pc_inc   = r_pc_inc;
  assign o_pc_d_in  = r_pc_d_in;
  assign o_mem_rd   = r_mem_rd;
  assign o_mem_addr = i_pc_value;
  assign o_ir_out   = r_ir;
  assign o_ir_valid = r_ir_valid;
  assign o_busy     = r_busy;
  assign o_fault    = r_fault;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a small PC register reacts to the strobes,
// stimulus changes and checks happen on the falling clock edge.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        halt_req;
  logic [15:0] pc_value;
  logic        mem_ready;
  logic [15:0] mem_data;
  logic        exec_done;
  logic        jump;
  logic [15:0] jump_addr;
`ifdef SEQ_STEP_EN
  logic        step = 1'b1;
`endif
  logic        pc_reset;
  logic        pc_load;
  logic        pc_inc;
  logic [15:0] pc_d_in;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [15:0] ir_out;
  logic        ir_valid;
  logic        busy;
  logic        fault;

  int n_vec = 0;
  int n_err = 0;
  int n_inc;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .WIDTH  (16),
    .TIMEOUT(15)
  ) u_dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_start    (start),
    .i_halt_req (halt_req),
    .i_pc_value (pc_value),
    .i_mem_ready(mem_ready),
    .i_mem_data (mem_data),
    .i_exec_done(exec_done),
    .i_jump     (jump),
    .i_jump_addr(jump_addr),
`ifdef SEQ_STEP_EN
    .i_step     (step),
`endif
    .o_pc_reset (pc_reset),
    .o_pc_load  (pc_load),
    .o_pc_inc   (pc_inc),
    .o_pc_d_in  (pc_d_in),
    .o_mem_rd   (mem_rd),
    .o_mem_addr (mem_addr),
    .o_ir_out   (ir_out),
    .o_ir_valid (ir_valid),
    .o_busy     (busy),
    .o_fault    (fault)
  );

  // Program counter that follows the sequencer's strobes.
  always_ff @(posedge clk) begin
    if (pc_reset)     pc_value <= 16'h0000;
    else if (pc_load) pc_value <= pc_d_in;
    else if (pc_inc)  pc_value <= pc_value + 16'h0001;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; halt_req = 1'b0; mem_ready = 1'b0; mem_data = 16'h0000;
    exec_done = 1'b0; jump = 1'b0; jump_addr = 16'h0000;
    cyc(2);
    check("rst_mem_rd", 32'(mem_rd), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ir_out", 32'(ir_out), 0);
    check("rst_ir_valid", 32'(ir_valid), 0);
    check("rst_fault", 32'(fault), 0);

    // Free-running: memory and execute respond immediately.
    reset = 1'b0; start = 1'b1; mem_ready = 1'b1; exec_done = 1'b1; mem_data = 16'h1234;
    check("post_rst_pc_reset", 32'(pc_reset), 1);
    cyc(1);  // FETCH
    check("fetch_pc_reset_off", 32'(pc_reset), 0);
    check("fetch_mem_rd", 32'(mem_rd), 1);
    check("fetch_busy", 32'(busy), 1);
    check("fetch_addr0", 32'(mem_addr), 32'h0000);
    cyc(1);  // DECODE
    check("decode_ir_out", 32'(ir_out), 32'h1234);
    check("decode_mem_rd", 32'(mem_rd), 0);
    cyc(1);  // EXEC
    check("exec_ir_valid", 32'(ir_valid), 1);
    cyc(1);  // UPDATE
    check("update_pc_inc", 32'(pc_inc), 1);
    check("update_pc_load", 32'(pc_load), 0);
    check("update_ir_valid", 32'(ir_valid), 0);
    cyc(1);  // FETCH pc=1
    check("fetch_addr1", 32'(mem_addr), 32'h0001);
    n_inc = 0;
    for (int i = 0; i < 8; i++) begin
      if (pc_inc) n_inc++;
      @(negedge clk);
    end
    check("inc_every_4th", 32'(n_inc), 2);
    check("fetch_addr3", 32'(mem_addr), 32'h0003);

    // Taken branch.
    jump = 1'b1; jump_addr = 16'h00A0;
    cyc(3);  // UPDATE
    check("jmp_pc_load", 32'(pc_load), 1);
    check("jmp_no_inc", 32'(pc_inc), 0);
    check("jmp_pc_d_in", 32'(pc_d_in), 32'h00A0);
    jump = 1'b0;
    cyc(1);
    check("jmp_target_addr", 32'(mem_addr), 32'h00A0);

    // PC wrap: branch to FFFF, then increment.
    jump = 1'b1; jump_addr = 16'hFFFF;
    cyc(3);
    jump = 1'b0;
    cyc(1);
    check("wrap_addr_ffff", 32'(mem_addr), 32'hFFFF);
    cyc(3);
    check("wrap_pc_inc", 32'(pc_inc), 1);
    cyc(1);
    check("wrap_addr_0000", 32'(mem_addr), 32'h0000);

    // Halt request raised during EXEC; start also high in UPDATE (halt wins).
    cyc(2);  // EXEC
    halt_req = 1'b1;
    cyc(1);  // UPDATE
    check("halt_upd_pc_inc", 32'(pc_inc), 1);
    cyc(1);  // HALT
    check("halt_busy", 32'(busy), 0);
    check("halt_mem_rd", 32'(mem_rd), 0);
    halt_req = 1'b0; start = 1'b0;
    cyc(1);
    check("halt_stays", 32'(busy), 0);
    start = 1'b1;
    cyc(1);
    check("resume_busy", 32'(busy), 1);
    check("resume_mem_rd", 32'(mem_rd), 1);
    check("resume_same_pc", 32'(mem_addr), 32'h0001);

    // mem_ready arrives on the 15th FETCH cycle: no fault.
    mem_ready = 1'b0; mem_data = 16'h5A5A;
    cyc(14);
    check("to15_mem_rd", 32'(mem_rd), 1);
    mem_ready = 1'b1;
    cyc(1);  // DECODE
    check("to15_no_fault", 32'(fault), 0);
    check("to15_ir_out", 32'(ir_out), 32'h5A5A);
    mem_ready = 1'b0;
    cyc(3);  // FETCH cycle 1
    check("to_fetch_again", 32'(mem_rd), 1);
    cyc(14);  // FETCH cycle 15
    check("to_cyc15_no_fault", 32'(fault), 0);
    check("to_cyc15_mem_rd", 32'(mem_rd), 1);
    cyc(1);
    check("to_fault", 32'(fault), 1);
    check("to_fault_mem_rd", 32'(mem_rd), 0);
    check("to_fault_busy", 32'(busy), 0);
    mem_ready = 1'b1;
    cyc(2);
    check("fault_sticky", 32'(fault), 1);
    check("fault_no_rd", 32'(mem_rd), 0);

    // Reset asserted mid-EXEC.
    reset = 1'b1;
    cyc(1);
    reset = 1'b0; exec_done = 1'b0;
    check("rst2_fault_clr", 32'(fault), 0);
    check("rst2_pc_reset", 32'(pc_reset), 1);
    cyc(3);  // EXEC, waiting
    check("rst2_exec_ir_valid", 32'(ir_valid), 1);
    #2 reset = 1'b1;
    #1 check("rst2_async_ir_valid", 32'(ir_valid), 0);
    check("rst2_async_busy", 32'(busy), 0);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("rst2_release_pc_reset", 32'(pc_reset), 1);
    cyc(1);
    check("rst2_idle_pc_reset_off", 32'(pc_reset), 0);
    check("rst2_idle_busy", 32'(busy), 0);
    check("rst2_idle_mem_rd", 32'(mem_rd), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
